hydra_port_sched: RTL and testbench
===================================

// Module: hydra_port_sched
// PURPOSE
//  Per-output-port packet scheduler for the hydra 4-port switch. Arbitrates
//  among 4 input-port queues holding packets for this output. Chooses by strict
//  priority or weighted round-robin. Sequences the granted queue onto the
//  rd_sop/rd_vld/rd_data/rd_eop stream, one packet per ready pulse.
//  One instance sits between the input-queue SRAM readers and each output port.
// PARAMETERS
//  NREQ      4    number of requesting input queues (ptr/credit widths sized for 4)
//  DW        16   data word width
//  AGE_LIMIT 8    grants a waiting requester may lose before forced service (aging only)
// PORTS
//  clk        in   1        single clock; all logic on posedge
//  rst        in   1        reset, asynchronous, active-high
//  ready      in   1        output-side pull pulse: send one packet
//  wrr_en     in   1        1 = weighted RR, 0 = strict priority
//  req        in   NREQ     queue i has >=1 complete packet for this port
//  req_hdr    in   NREQ*DW  head-packet header of queue i, see header format
//  src_rd     out  NREQ     one-hot read strobe to granted queue
//  src_data   in   NREQ*DW  queue words; valid the cycle after src_rd
//  grant      out  NREQ     one-hot, held from ARB exit through EOP
//  rd_sop     out  1        packet start strobe
//  rd_vld     out  1        rd_data valid
//  rd_data    out  DW       packet word (header first)
//  rd_eop     out  1        packet end strobe
// BEHAVIOUR
//  Reset:
//  - Async reset: state=IDLE; all outputs 0; pend=0; rr_ptr=0.
//  - Credits reload to prio+1; aging counters 0.
//  - Reset mid-packet aborts the packet: no rd_eop is emitted.
//  Header word: [1:0] dest, [3:2] prio (3 highest), [11:4] len, [15:12] rsvd.
//  - Packet = header + len payload words.
//  - len=0 is legal (header only).
//  Ready handling:
//  - Ready pulse sets pend; pend is one deep, so extra pulses while pend=1 are dropped.
//  - Pulses arriving during a transfer are latched and served after EOP.
//  FSM IDLE->ARB->SOP->DATA->EOP->IDLE:
//  - IDLE: pend && |req -> ARB. pend with no req waits indefinitely.
//  - ARB (1 cyc): pick winner, register grant, latch len, clear pend.
//  - SOP (1 cyc): rd_sop=1; src_rd[g]=1 fetches the header.
//  - DATA (len+1 cyc): rd_vld=1; rd_data=src_data[g] (header, then payload).
//    src_rd[g]=1 during the first len DATA cycles, so len+1 strobes total.
//  - EOP (1 cyc): rd_eop=1, rd_vld=0. Next state is ARB if pend && |req, else IDLE.
//  Latency: ready at cycle N -> ARB N+1, rd_sop N+2, header on rd_data N+3.
//  - From a latched pend, the next rd_sop follows EOP by 2 cycles.
//  Strict (wrr_en=0):
//  - Highest prio wins.
//  - Ties go to the first requester at or after rr_ptr.
//  - rr_ptr <= winner+1 mod NREQ.
//  WRR (wrr_en=1):
//  - Each queue holds credit = prio+1 (1..4).
//  - Winner = first requester at or after rr_ptr with credit>0; winner credit -1.
//  - rr_ptr advances only when the winner's credit reaches 0.
//  - If every requester has credit 0, reload all to prio+1 in the same ARB cycle, then pick.
//  Other rules:
//  - req/req_hdr are sampled only in ARB. Deassertion mid-packet is ignored; the packet completes.
//  - wrr_en changes take effect at the next ARB.
// CONFIGURATION
//  HYDRA_SCHED_AGING_EN:
//  - Defined: per-queue age counter; +1 when requesting and losing ARB, 0 on grant.
//    Age >= AGE_LIMIT overrides both modes; lowest index among aged wins.
//  - Undefined: no counters; arbitration exactly as above.
// TESTING
//  T1: req=4'h8, hdr len=31 prio=1; ready pulse at N
//      -> rd_sop N+2; 32 rd_vld (hdr then words); rd_eop N+35; src_rd[3]=32 pulses.
//  T2: wrr_en=0, q0 prio0, q2 prio3, both req; 2 ready pulses
//      -> q2 twice; q0 never while q2 requests.
//  T3: wrr_en=1, all 4 req, prio {3,2,1,0} for q0..q3; 10 pulses
//      -> grants q0x4, q1x3, q2x2, q3x1, then credits reload.
//  T4: len=0; ready -> rd_sop, 1 rd_vld (hdr), rd_eop.
//      Second ready during DATA -> next rd_sop 2 cycles after rd_eop.
//  T5: rst asserted mid-DATA -> all outputs 0 immediately, no rd_eop.
//      ready after release -> fresh packet from rr_ptr=0.
//  T6 (AGING_EN, AGE_LIMIT=2): wrr_en=0, q1 prio0 vs q0 prio3 -> q1 granted on the 3rd pulse.

Source files
------------

// File: rtl/hydra_port_sched.sv
// hydra_port_sched: per-output-port packet scheduler, strict priority or weighted round-robin.
// Define HYDRA_SCHED_AGING_EN to add per-queue aging that forces service of starved queues.
module hydra_port_sched #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 16,
    parameter int unsigned AGE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ready,
    input  logic               wrr_en,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_hdr,
    output logic [NREQ-1:0]    src_rd,
    input  logic [NREQ*DW-1:0] src_data,
    output logic [NREQ-1:0]    grant,
    output logic               rd_sop,
    output logic               rd_vld,
    output logic [DW-1:0]      rd_data,
    output logic               rd_eop
);
    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = 3;
    localparam int unsigned LW = 8;

    typedef enum logic [2:0] {IDLE, ARB, SOP, DATA, EOP} state_t;

    state_t          state;
    logic            pend;
    logic [PW-1:0]   rr_ptr;
    logic [LW-1:0]   cnt;
    logic [CW-1:0]   cred [NREQ];
    logic [NREQ-1:0] cred_vld;   // 0: credit is implicitly prio+1 of the current header

    logic [1:0]      prio [NREQ];
    logic [LW-1:0]   hlen [NREQ];
    logic [CW-1:0]   eff_cred [NREQ];
    logic            reload_c;
    logic            found_c;
    logic            wrr_upd_c;
    logic [PW-1:0]   win_c;
    logic [CW-1:0]   win_cred_c;
    logic [NREQ-1:0] win_oh_c;
    logic            go_arb_c;
    logic            sched_unused;

`ifdef HYDRA_SCHED_AGING_EN
    localparam int unsigned AW = $clog2(AGE_LIMIT + 1);
    logic [AW-1:0]   age [NREQ];
    logic            aged_c;
`endif

    assign sched_unused = ^{req_hdr, 32'(AGE_LIMIT)};
    assign go_arb_c     = (pend | ready) & (|req);

    // Header field decode per queue
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            prio[i] = req_hdr[i*DW+2 +: 2];
            hlen[i] = req_hdr[i*DW+4 +: LW];
        end
    end

    // Winner selection; credits reload in-cycle when every requester is exhausted
    always_comb begin
        logic [PW-1:0] idx;
        logic [1:0]    best;
        reload_c  = 1'b1;
        found_c   = 1'b0;
        win_c     = '0;
        best      = '0;
        idx       = '0;
        wrr_upd_c = wrr_en;
        for (int i = 0; i < NREQ; i++)
            eff_cred[i] = cred_vld[i] ? cred[i] : CW'(prio[i]) + CW'(1);
        for (int i = 0; i < NREQ; i++)
            if (req[i] && eff_cred[i] != '0) reload_c = 1'b0;
        for (int i = 0; i < NREQ; i++)
            if (reload_c) eff_cred[i] = CW'(prio[i]) + CW'(1);
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr + PW'(k);
            if (wrr_en) begin
                if (!found_c && req[idx] && eff_cred[idx] != '0) begin
                    found_c = 1'b1;
                    win_c   = idx;
                end
            end else if (req[idx] && (!found_c || prio[idx] > best)) begin
                found_c = 1'b1;
                win_c   = idx;
                best    = prio[idx];
            end
        end
`ifdef HYDRA_SCHED_AGING_EN
        aged_c = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && age[i] >= AW'(AGE_LIMIT)) begin
                aged_c  = 1'b1;
                found_c = 1'b1;
                win_c   = PW'(i);
            end
        end
        wrr_upd_c = wrr_en && !aged_c;
`endif
        win_cred_c = eff_cred[win_c] - CW'(1);
        win_oh_c   = NREQ'(1) << win_c;
    end

    // Output word comes straight from the granted queue's read port
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (rd_vld && grant[i]) rd_data = src_data[i*DW +: DW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pend     <= 1'b0;
            rr_ptr   <= '0;
            cnt      <= '0;
            grant    <= '0;
            src_rd   <= '0;
            rd_sop   <= 1'b0;
            rd_vld   <= 1'b0;
            rd_eop   <= 1'b0;
            cred_vld <= '0;
            for (int i = 0; i < NREQ; i++) cred[i] <= '0;
`ifdef HYDRA_SCHED_AGING_EN
            for (int i = 0; i < NREQ; i++) age[i] <= '0;
`endif
        end else begin
            rd_sop <= 1'b0;
            rd_eop <= 1'b0;
            src_rd <= '0;
            if (ready)
                pend <= 1'b1;
            else if (state == ARB && found_c)
                pend <= 1'b0;

            case (state)
                IDLE: if (go_arb_c) state <= ARB;
                ARB: begin
                    if (!found_c) begin
                        state <= IDLE;
                    end else begin
                        state  <= SOP;
                        grant  <= win_oh_c;
                        src_rd <= win_oh_c;
                        rd_sop <= 1'b1;
                        cnt    <= hlen[win_c];
                        if (wrr_upd_c) begin
                            if (reload_c) cred_vld <= '0;
                            cred[win_c]     <= win_cred_c;
                            cred_vld[win_c] <= 1'b1;
                            if (win_cred_c == '0) rr_ptr <= win_c + PW'(1);
                        end else begin
                            rr_ptr <= win_c + PW'(1);
                        end
`ifdef HYDRA_SCHED_AGING_EN
                        for (int i = 0; i < NREQ; i++) begin
                            if (PW'(i) == win_c)
                                age[i] <= '0;
                            else if (req[i] && age[i] != AW'(AGE_LIMIT))
                                age[i] <= age[i] + AW'(1);
                        end
`endif
                    end
                end
                SOP: begin
                    state  <= DATA;
                    rd_vld <= 1'b1;
                    src_rd <= (cnt != '0) ? grant : '0;
                end
                DATA: begin
                    if (cnt == '0) begin
                        state  <= EOP;
                        rd_vld <= 1'b0;
                        rd_eop <= 1'b1;
                    end else begin
                        cnt    <= cnt - LW'(1);
                        src_rd <= (cnt > LW'(1)) ? grant : '0;
                    end
                end
                EOP: begin
                    grant <= '0;
                    state <= go_arb_c ? ARB : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hydra_port_sched.sv
// Scoreboard bench for hydra_port_sched: directed packets, timing and arbitration order.
module tb_hydra_port_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 16;
`ifdef HYDRA_SCHED_AGING_EN
    localparam int unsigned AGE_LIMIT = 2;
`else
    localparam int unsigned AGE_LIMIT = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b0;
    logic        wrr_en = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [63:0] req_hdr;
    logic [63:0] src_data;
    logic [3:0]  src_rd;
    logic [3:0]  grant;
    logic        rd_sop, rd_vld, rd_eop;
    logic [15:0] rd_data;

    typedef struct packed { logic [3:0] g; logic [15:0] d; } word_t;
    typedef struct packed { logic [3:0] g; logic [15:0] n; } pkt_t;

    logic [15:0] hdr [4];
    int          qidx [4];
    int          rdcnt [4];
    int          cyc, n_pass, n_total, eop_cnt, vcnt;
    word_t       exp_w [$];
    pkt_t        exp_p [$];
    int          sop_q [$];
    int          eop_q [$];
    int          vld_q [$];

    hydra_port_sched #(.NREQ(NREQ), .DW(DW), .AGE_LIMIT(AGE_LIMIT)) dut (
        .clk(clk), .rst(rst), .ready(ready), .wrr_en(wrr_en), .req(req),
        .req_hdr(req_hdr), .src_rd(src_rd), .src_data(src_data), .grant(grant),
        .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_data(rd_data), .rd_eop(rd_eop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign req_hdr = {hdr[3], hdr[2], hdr[1], hdr[0]};

    function automatic logic [15:0] mk_hdr(int len, int prio);
        return 16'((len << 4) | (prio << 2));
    endfunction
    function automatic logic [15:0] payload(int q, int k);
        return 16'(32'hD000 | (q << 8) | k);
    endfunction
    function automatic int hlen(logic [15:0] h);
        return int'(h[11:4]);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Queue SRAM reader model: header then payload words, one per strobe, data next cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            src_data <= '0;
            for (int i = 0; i < 4; i++) qidx[i] <= 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (src_rd[i]) begin
                    src_data[i*16 +: 16] <= (qidx[i] == 0) ? hdr[i] : payload(i, qidx[i]);
                    qidx[i] <= (qidx[i] >= hlen(hdr[i])) ? 0 : qidx[i] + 1;
                end
            end
        end
    end

    // Monitor: pops expected words/packets whenever the DUT presents them
    always @(negedge clk) begin
        word_t w;
        pkt_t  p;
        if (!rst) begin
            if (rd_sop) begin
                sop_q.push_back(cyc);
                vcnt = 0;
            end
            if (rd_vld) begin
                if (vcnt == 0) vld_q.push_back(cyc);
                vcnt++;
                if (exp_w.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_word: got %0h with nothing expected at cycle %0d", rd_data, cyc);
                end else begin
                    w = exp_w.pop_front();
                    check("word", 32'({grant, rd_data}), 32'(w));
                end
            end
            if (rd_eop) begin
                eop_q.push_back(cyc);
                eop_cnt++;
                if (exp_p.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_pkt: grant %0h with nothing expected at cycle %0d", grant, cyc);
                end else begin
                    p = exp_p.pop_front();
                    check("pkt_grant", 32'(grant), 32'(p.g));
                    check("pkt_len", 32'(vcnt), 32'(p.n));
                end
            end
            for (int i = 0; i < 4; i++) if (src_rd[i]) rdcnt[i]++;
        end
    end

    task automatic push_pkt(int q);
        word_t w;
        pkt_t  p;
        int    len;
        len = hlen(hdr[q]);
        for (int k = 0; k <= len; k++) begin
            w.g = 4'(1 << q);
            w.d = (k == 0) ? hdr[q] : payload(q, k);
            exp_w.push_back(w);
        end
        p.g = 4'(1 << q);
        p.n = 16'(len + 1);
        exp_p.push_back(p);
    endtask

    task automatic pulse(output int c);
        @(posedge clk); #1;
        ready = 1'b1;
        c = cyc;
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    task automatic wait_eops(int target);
        int n;
        n = 0;
        while (eop_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("eop_count", 32'(eop_cnt), 32'(target));
    endtask

    task automatic clear_logs();
        sop_q.delete();
        eop_q.delete();
        vld_q.delete();
        for (int i = 0; i < 4; i++) rdcnt[i] = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_w.delete();
        exp_p.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c0, c1, e0;
        int seq3 [11];
        int seq6 [3];
        seq3 = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3, 0};
        seq6 = '{0, 0, 1};
        for (int i = 0; i < 4; i++) hdr[i] = 16'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_src_rd", 32'(src_rd), 32'h0);
        check("rst_sop", 32'(rd_sop), 32'h0);
        check("rst_vld", 32'(rd_vld), 32'h0);
        check("rst_eop", 32'(rd_eop), 32'h0);
        check("rst_data", 32'(rd_data), 32'h0);
        rst = 1'b0;

        // T1: single long packet, latency and strobe count
        hdr[3] = mk_hdr(31, 1);
        req = 4'h8;
        clear_logs();
        e0 = eop_cnt;
        push_pkt(3);
        pulse(c0);
        wait_eops(e0 + 1);
        check("t1_sop_cyc", 32'(sop_q[0]), 32'(c0 + 2));
        check("t1_hdr_cyc", 32'(vld_q[0]), 32'(c0 + 3));
        check("t1_eop_cyc", 32'(eop_q[0]), 32'(c0 + 35));
        check("t1_src_rd3", 32'(rdcnt[3]), 32'd32);
        check("t1_drained", 32'(exp_w.size()), 32'd0);

        // T2: strict priority, q2 beats q0 every time
        req = 4'h0;
        hdr[0] = mk_hdr(2, 0);
        hdr[2] = mk_hdr(1, 3);
        req = 4'b0101;
        wrr_en = 1'b0;
        clear_logs();
        e0 = eop_cnt;
        push_pkt(2);
        pulse(c0);
        wait_eops(e0 + 1);
        push_pkt(2);
        pulse(c0);
        wait_eops(e0 + 2);
        check("t2_q0_idle", 32'(rdcnt[0]), 32'd0);
        check("t2_q2_rd", 32'(rdcnt[2]), 32'd4);

        // T4: header-only packet, second ready latched during DATA
        req = 4'b0010;
        hdr[1] = mk_hdr(0, 2);
        clear_logs();
        e0 = eop_cnt;
        push_pkt(1);
        push_pkt(1);
        pulse(c0);
        @(posedge clk);
        pulse(c1);
        wait_eops(e0 + 2);
        check("t4_hdr_cyc", 32'(vld_q[0]), 32'(c0 + 3));
        check("t4_eop_cyc", 32'(eop_q[0]), 32'(c0 + 4));
        check("t4_gap", 32'(sop_q[1]), 32'(eop_q[0] + 2));
        check("t4_src_rd1", 32'(rdcnt[1]), 32'd2);

        // T5: reset mid-DATA aborts; afterwards arbitration restarts at queue 0
        req = 4'b0001;
        hdr[0] = mk_hdr(10, 0);
        clear_logs();
        push_pkt(0);
        pulse(c0);
        repeat (4) @(posedge clk);
        #1;
        check("t5_pre_vld", 32'(rd_vld), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_vld", 32'(rd_vld), 32'h0);
        check("t5_data", 32'(rd_data), 32'h0);
        check("t5_grant", 32'(grant), 32'h0);
        check("t5_src_rd", 32'(src_rd), 32'h0);
        check("t5_eop", 32'(rd_eop), 32'h0);
        exp_w.delete();
        exp_p.delete();
        e0 = eop_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hdr[0] = mk_hdr(1, 2);
        hdr[1] = mk_hdr(1, 2);
        req = 4'b0011;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_eop", 32'(eop_cnt), 32'(e0));
        clear_logs();
        push_pkt(0);
        pulse(c0);
        wait_eops(e0 + 1);
        check("t5_sop_cyc", 32'(sop_q[0]), 32'(c0 + 2));

`ifndef HYDRA_SCHED_AGING_EN
        // T3: weighted RR, grants 4/3/2/1 then reload
        do_reset();
        wrr_en = 1'b1;
        for (int i = 0; i < 4; i++) hdr[i] = mk_hdr(1, 3 - i);
        req = 4'hF;
        clear_logs();
        e0 = eop_cnt;
        for (int k = 0; k < 11; k++) begin
            push_pkt(seq3[k]);
            pulse(c0);
            wait_eops(e0 + k + 1);
        end
        check("t3_q0_rd", 32'(rdcnt[0]), 32'd10);
        check("t3_q1_rd", 32'(rdcnt[1]), 32'd6);
        check("t3_q3_rd", 32'(rdcnt[3]), 32'd2);
`else
        // T6: aged low-priority queue forced through on the third grant
        do_reset();
        wrr_en = 1'b0;
        for (int i = 0; i < 4; i++) hdr[i] = 16'h0;
        hdr[0] = mk_hdr(0, 3);
        hdr[1] = mk_hdr(0, 0);
        req = 4'b0011;
        clear_logs();
        e0 = eop_cnt;
        for (int k = 0; k < 3; k++) begin
            push_pkt(seq6[k]);
            pulse(c0);
            wait_eops(e0 + k + 1);
        end
        check("t6_q1_rd", 32'(rdcnt[1]), 32'd1);
`endif

        req = 4'h0;
        repeat (4) @(posedge clk);
        #1;
        check("end_drained_w", 32'(exp_w.size()), 32'd0);
        check("end_drained_p", 32'(exp_p.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
